// File: rtl/pred_regfile_mp.sv
// Multi-ported 1-bit predicate register file with set/and/or/xor write ops and one-deep shadow.
// Define PRED_REGFILE_BYPASS_EN to forward same-cycle write results onto rd_data.
module pred_regfile_mp #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*2-1:0]        wr_op,
  input  logic [NUM_WR-1:0]          wr_data,
  input  logic                       clear_all,
  input  logic                       save,
  input  logic                       restore,
  output logic                       shadow_valid,
  output logic [NUM_REGS-1:0]        pred_vec
);

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] VEC_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  function automatic logic apply_op(input logic q, input logic [1:0] op, input logic d);
    case (op)
      OP_SET:  return d;
      OP_AND:  return q & d;
      OP_OR:   return q | d;
      OP_XOR:  return q ^ d;
      default: return d;
    endcase
  endfunction

  logic [NUM_REGS-1:0] r_regs;
  logic [NUM_REGS-1:0] r_shadow;
  logic                r_shadow_valid;

  logic [NUM_REGS-1:0] w_wr_vec;
  logic [NUM_REGS-1:0] w_next_vec;
  logic                w_restore_valid;

  assign w_restore_valid = restore & r_shadow_valid;

  // Port writes against pre-edge state; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    w_wr_vec = r_regs;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          w_wr_vec[r] = apply_op(r_regs[r], wr_op[p*2 +: 2], wr_data[p]);
        end else begin
          w_wr_vec[r] = w_wr_vec[r];
        end
      end
    end
    w_wr_vec[0] = 1'b1;
  end

  // Whole-vector priority: valid restore, then clear, then port writes.
  always_comb begin
    if (w_restore_valid) begin
      w_next_vec = r_shadow | VEC_ONE;
    end else if (clear_all) begin
      w_next_vec = VEC_ONE;
    end else begin
      w_next_vec = w_wr_vec;
    end
  end

  // Predicate register state; bit 0 is held at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= VEC_ONE;
    end else begin
      r_regs <= w_next_vec;
    end
  end

  // Shadow capture; a save alongside a valid restore swaps and keeps the shadow valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow       <= {NUM_REGS{1'b0}};
      r_shadow_valid <= 1'b0;
    end else if (save) begin
      r_shadow       <= r_regs;
      r_shadow_valid <= 1'b1;
    end else if (w_restore_valid) begin
      r_shadow       <= r_shadow;
      r_shadow_valid <= 1'b0;
    end else begin
      r_shadow       <= r_shadow;
      r_shadow_valid <= r_shadow_valid;
    end
  end

  // Combinational read ports, optionally forwarding the next-state bit on an address hit.
  always_comb begin
    logic [ADDR_W-1:0] v_addr;
    logic              v_hit;
    rd_data = {NUM_RD{1'b0}};
    v_addr  = {ADDR_W{1'b0}};
    v_hit   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      v_addr = rd_addr[i*ADDR_W +: ADDR_W];
      v_hit  = 1'b0;
`ifdef PRED_REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == v_addr) && (v_addr != {ADDR_W{1'b0}})) begin
          v_hit = 1'b1;
        end else begin
          v_hit = v_hit;
        end
      end
`else
      v_hit = 1'b0;
`endif
      if ({1'b0, v_addr} >= NREGS_W) begin
        rd_data[i] = 1'b0;
      end else if (v_hit) begin
        rd_data[i] = w_next_vec[v_addr];
      end else begin
        rd_data[i] = r_regs[v_addr];
      end
    end
  end

  assign pred_vec     = r_regs;
  assign shadow_valid = r_shadow_valid;

endmodule

// File: tb/tb_pred_regfile_mp.sv
// Directed self-checking bench for pred_regfile_mp (default 16 regs, 2 read, 2 write ports).
module tb_pred_regfile_mp;

  localparam logic [1:0] SET = 2'b00;
  localparam logic [1:0] AND = 2'b01;
  localparam logic [1:0] OR_ = 2'b10;
  localparam logic [1:0] XOR = 2'b11;

`ifdef PRED_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_data;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_op;
  logic [1:0]  wr_data;
  logic        clear_all;
  logic        save;
  logic        restore;
  logic        shadow_valid;
  logic [15:0] pred_vec;

  int n_checks;
  int n_errors;

  pred_regfile_mp dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_op        (wr_op),
    .wr_data      (wr_data),
    .clear_all    (clear_all),
    .save         (save),
    .restore      (restore),
    .shadow_valid (shadow_valid),
    .pred_vec     (pred_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_en     = 2'b00;
    wr_addr   = 8'h00;
    wr_op     = 4'h0;
    wr_data   = 2'b00;
    clear_all = 1'b0;
    save      = 1'b0;
    restore   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic set_wr(input int p, input logic [3:0] a, input logic [1:0] op, input logic d);
    wr_en[p]         = 1'b1;
    wr_addr[p*4 +: 4] = a;
    wr_op[p*2 +: 2]   = op;
    wr_data[p]       = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr();
    reset_n = 1'b0;
    rd_addr = {4'd5, 4'd0};
    repeat (3) tick();
    chk("rst_pred", pred_vec, 32'h0001);
    reset_n = 1'b1;
    tick();
    chk("rst_rd", rd_data, 32'h1);
    chk("rst_pred_after", pred_vec, 32'h0001);
    chk("rst_sv", shadow_valid, 32'h0);

    // op chain on reg 3
    rd_addr = {4'd0, 4'd3};
    set_wr(0, 4'd3, SET, 1'b1);
    #1;
    chk("set_pre_edge_rd", rd_data, BYP ? 32'h3 : 32'h2);
    tick();
    chk("set_pred", pred_vec, 32'h0009);
    chk("set_rd", rd_data, 32'h3);
    set_wr(0, 4'd3, AND, 1'b0); tick(); chk("and_pred", pred_vec, 32'h0001);
    set_wr(0, 4'd3, OR_, 1'b1); tick(); chk("or_pred", pred_vec, 32'h0009);
    set_wr(0, 4'd3, XOR, 1'b1); tick(); chk("xor_pred", pred_vec, 32'h0001);

    // collisions and reg 0
    set_wr(0, 4'd7, SET, 1'b1); set_wr(1, 4'd7, SET, 1'b0); tick();
    chk("coll_hi_wins0", pred_vec, 32'h0001);
    set_wr(0, 4'd7, SET, 1'b0); set_wr(1, 4'd7, SET, 1'b1); tick();
    chk("coll_hi_wins1", pred_vec, 32'h0081);
    set_wr(0, 4'd7, SET, 1'b0); set_wr(1, 4'd7, XOR, 1'b1); tick();
    chk("coll_old_q", pred_vec, 32'h0001);
    set_wr(0, 4'd2, SET, 1'b1); set_wr(1, 4'd4, SET, 1'b1); tick();
    chk("two_ports", pred_vec, 32'h0015);
    set_wr(0, 4'd0, SET, 1'b0); set_wr(1, 4'd0, XOR, 1'b1); tick();
    chk("reg0_write", pred_vec, 32'h0015);

    // save / clear / restore
    save = 1'b1; tick();
    chk("save_sv", shadow_valid, 32'h1);
    chk("save_pred", pred_vec, 32'h0015);
    clear_all = 1'b1; tick();
    chk("clear_pred", pred_vec, 32'h0001);
    chk("clear_sv", shadow_valid, 32'h1);
    restore = 1'b1; tick();
    chk("restore_pred", pred_vec, 32'h0015);
    chk("restore_sv", shadow_valid, 32'h0);
    restore = 1'b1; set_wr(0, 4'd5, SET, 1'b1); tick();
    chk("restore_inv_wr", pred_vec, 32'h0035);
    restore = 1'b1; clear_all = 1'b1; tick();
    chk("restore_inv_clr", pred_vec, 32'h0001);

    // priority: restore over clear over writes
    set_wr(0, 4'd8, SET, 1'b1); tick();
    save = 1'b1; tick();
    clear_all = 1'b1; tick();
    set_wr(0, 4'd1, SET, 1'b1); tick();
    chk("prio_setup", pred_vec, 32'h0003);
    restore = 1'b1; clear_all = 1'b1; set_wr(0, 4'd5, SET, 1'b1); tick();
    chk("prio_pred", pred_vec, 32'h0101);
    chk("prio_sv", shadow_valid, 32'h0);

    // swap: save with valid restore
    save = 1'b1; tick();
    clear_all = 1'b1; tick();
    set_wr(0, 4'd1, SET, 1'b1); tick();
    restore = 1'b1; clear_all = 1'b1; save = 1'b1; set_wr(0, 4'd5, SET, 1'b1); tick();
    chk("swap_pred", pred_vec, 32'h0101);
    chk("swap_sv", shadow_valid, 32'h1);
    restore = 1'b1; tick();
    chk("swap_shadow", pred_vec, 32'h0003);
    chk("swap_sv_after", shadow_valid, 32'h0);

    // save captures pre-write vector
    save = 1'b1; set_wr(0, 4'd6, SET, 1'b1); tick();
    chk("save_wr_pred", pred_vec, 32'h0043);
    restore = 1'b1; tick();
    chk("save_prewrite", pred_vec, 32'h0003);

    // same-cycle read of a write
    rd_addr = {4'd9, 4'd9};
    set_wr(1, 4'd9, SET, 1'b1);
    #1;
    chk("byp_rd", rd_data, BYP ? 32'h3 : 32'h0);
    tick();
    chk("byp_rd_next", rd_data, 32'h3);
    chk("byp_pred", pred_vec, 32'h0203);
    set_wr(0, 4'd9, SET, 1'b1); clear_all = 1'b1;
    #1;
    chk("byp_clr_rd", rd_data, BYP ? 32'h0 : 32'h3);
    tick();
    chk("byp_clr_pred", pred_vec, 32'h0001);

    // async reset mid-write
    set_wr(0, 4'd9, SET, 1'b1); tick();
    save = 1'b1; tick();
    chk("pre_rst_sv", shadow_valid, 32'h1);
    set_wr(0, 4'd10, SET, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pred", pred_vec, 32'h0001);
    chk("async_rst_sv", shadow_valid, 32'h0);
    chk("async_rst_rd", rd_data, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_pred", pred_vec, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
